// File: rtl/urv_dmem_responder.sv
// uRV data-memory target: word-wide RAM with byte-lane stores, address window
// decode and programmable wait states before each access completes.
module urv_dmem_responder #(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_store_i,
    input  logic        dm_load_i,
    output logic        dm_ready_o,
    output logic [31:0] dm_data_l_o,
    output logic        dm_load_done_o,
    output logic        dm_store_done_o,
    output logic        dm_error_o
);

    localparam int unsigned AW     = $clog2(MEM_WORDS);
    localparam logic [3:0]  WsInit = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic {StIdle, StWait} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]  sel_q, sel_d;
    logic        store_q, store_d, both_q, both_d;
    logic        ready_q, ready_d;
    logic        load_done_q, load_done_d, store_done_q, store_done_d;
    logic        error_q, error_d;
    logic [31:0] data_l_q, data_l_d;

    logic [31:0] mem [MEM_WORDS];

    logic          req, acc_en, acc_store, acc_both, acc_in, mem_we;
    logic [31:0]   acc_addr, acc_data, acc_off;
    logic [3:0]    acc_sel;
    logic [AW-1:0] acc_idx;

    assign req = dm_load_i | dm_store_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        store_d = store_q;
        both_d  = both_q;
        acc_en  = 1'b0;

        // In IDLE a zero-wait access uses the live request; in WAIT the latched one.
        if (state_q == StWait) begin
            acc_addr  = addr_q;
            acc_data  = wdata_q;
            acc_sel   = sel_q;
            acc_store = store_q;
            acc_both  = both_q;
        end else begin
            acc_addr  = dm_addr_i;
            acc_data  = dm_data_s_i;
            acc_sel   = dm_data_select_i;
            acc_store = dm_store_i;
            acc_both  = dm_load_i & dm_store_i;
        end

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    addr_d  = dm_addr_i;
                    wdata_d = dm_data_s_i;
                    sel_d   = dm_data_select_i;
                    store_d = dm_store_i;
                    both_d  = dm_load_i & dm_store_i;
                    if (WAIT_STATES == 0) begin
                        acc_en = 1'b1;
                    end else begin
                        cnt_d   = WsInit;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    acc_en  = 1'b1;
                    state_d = StIdle;
                end
            end
        endcase

        // Unsigned 32-bit difference: addresses below the base wrap out of range.
        acc_off = acc_addr - ADDR_BASE;
        acc_in  = (acc_off >> 2) < 32'(MEM_WORDS);
        acc_idx = acc_off[AW+1:2];
        mem_we  = acc_en & acc_store & acc_in;

        ready_d      = (state_d == StIdle);
        load_done_d  = acc_en & ~acc_store;
        store_done_d = acc_en & acc_store;
        error_d      = acc_en & (~acc_in | acc_both);
        data_l_d     = data_l_q;
        if (acc_en && !acc_store) begin
            data_l_d = acc_in ? mem[acc_idx] : 32'h0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            sel_q        <= 4'h0;
            store_q      <= 1'b0;
            both_q       <= 1'b0;
            ready_q      <= 1'b1;
            load_done_q  <= 1'b0;
            store_done_q <= 1'b0;
            error_q      <= 1'b0;
            data_l_q     <= 32'h0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            sel_q        <= sel_d;
            store_q      <= store_d;
            both_q       <= both_d;
            ready_q      <= ready_d;
            load_done_q  <= load_done_d;
            store_done_q <= store_done_d;
            error_q      <= error_d;
            data_l_q     <= data_l_d;
        end
    end

    // RAM is not reset; a write is suppressed while reset is held.
    always_ff @(posedge clk_i) begin
        if (mem_we && !rst_i) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_sel[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_data[8*i +: 8];
                end
            end
        end
    end

    assign dm_ready_o      = ready_q;
    assign dm_data_l_o     = data_l_q;
    assign dm_load_done_o  = load_done_q;
    assign dm_store_done_o = store_done_q;
    assign dm_error_o      = error_q;

endmodule

// File: tb/tb_urv_dmem_responder.sv
// Bench for urv_dmem_responder: a zero-wait instance (base 0) and a three-wait
// instance (base 0x100), both 16 words, checked against an array-based model.
module tb_urv_dmem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0][31:0] addr, wdata, dl;
    logic [1:0][3:0]  sel;
    logic [1:0]       ld, st, ready, ldone, sdone, err;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl    [2][16];
    logic [31:0] exp_dl [2];

    urv_dmem_responder #(.MEM_WORDS(16), .ADDR_BASE(32'h0), .WAIT_STATES(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .dm_addr_i(addr[0]), .dm_data_s_i(wdata[0]),
        .dm_data_select_i(sel[0]), .dm_store_i(st[0]), .dm_load_i(ld[0]),
        .dm_ready_o(ready[0]), .dm_data_l_o(dl[0]), .dm_load_done_o(ldone[0]),
        .dm_store_done_o(sdone[0]), .dm_error_o(err[0])
    );

    urv_dmem_responder #(.MEM_WORDS(16), .ADDR_BASE(32'h100), .WAIT_STATES(3)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .dm_addr_i(addr[1]), .dm_data_s_i(wdata[1]),
        .dm_data_select_i(sel[1]), .dm_store_i(st[1]), .dm_load_i(ld[1]),
        .dm_ready_o(ready[1]), .dm_data_l_o(dl[1]), .dm_load_done_o(ldone[1]),
        .dm_store_done_o(sdone[1]), .dm_error_o(err[1])
    );

    typedef struct {
        logic        l, s;
        logic [31:0] a, w;
        logic [3:0]  se;
        logic        eld, esd, eerr;
        logic [31:0] edl;
    } vec_t;
    vec_t tv [15];

    function automatic logic [31:0] base_of(input int d);
        return (d == 1) ? 32'h100 : 32'h0;
    endfunction

    // Reference: byte-address window, lane merge, load result register.
    task automatic model(input int d, input logic l, input logic s, input logic [31:0] a,
                         input logic [31:0] w, input logic [3:0] se,
                         output logic eld, output logic esd, output logic eerr);
        logic [31:0] off;
        logic        inwin;
        logic [3:0]  wi;
        off   = a - base_of(d);
        inwin = (off / 4) < 16;
        wi    = off[5:2];
        esd   = s;
        eld   = l & ~s;
        eerr  = (l | s) & (~inwin | (l & s));
        if (s && inwin)
            for (int i = 0; i < 4; i++)
                if (se[i]) mdl[d][wi][8*i +: 8] = w[8*i +: 8];
        if (eld) exp_dl[d] = inwin ? mdl[d][wi] : 32'h0;
    endtask

    task automatic drive(input int d, input logic l, input logic s, input logic [31:0] a,
                         input logic [31:0] w, input logic [3:0] se);
        ld[d] = l; st[d] = s; addr[d] = a; wdata[d] = w; sel[d] = se;
    endtask

    task automatic chk_outs(input int d, input string name, input logic erdy, input logic eld,
                            input logic esd, input logic eerr, input logic [31:0] edl);
        logic [35:0] act, exp;
        act = {ready[d], ldone[d], sdone[d], err[d], dl[d]};
        exp = {erdy, eld, esd, eerr, edl};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got rdy/ld/sd/err/data=%h expected %h", name, d, act, exp);
        end
    endtask

    task automatic step0(input logic l, input logic s, input logic [31:0] a,
                         input logic [31:0] w, input logic [3:0] se);
        logic eld, esd, eerr;
        model(0, l, s, a, w, se, eld, esd, eerr);
        drive(0, l, s, a, w, se);
        @(posedge clk);
        @(negedge clk);
        chk_outs(0, "rand_ws0", 1'b1, eld, esd, eerr, exp_dl[0]);
    endtask

    // Strobes stay asserted through the busy window to prove they are not re-accepted.
    task automatic access1(input logic l, input logic s, input logic [31:0] a,
                           input logic [31:0] w, input logic [3:0] se, input string name);
        logic eld, esd, eerr;
        logic [31:0] prev;
        prev = exp_dl[1];
        model(1, l, s, a, w, se, eld, esd, eerr);
        drive(1, l, s, a, w, se);
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_outs(1, {name, "_busy"}, 1'b0, 1'b0, 1'b0, 1'b0, prev);
            @(posedge clk);
        end
        @(negedge clk);
        chk_outs(1, {name, "_done"}, 1'b1, eld, esd, eerr, exp_dl[1]);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge clk);
        @(negedge clk);
        chk_outs(1, {name, "_quiet"}, 1'b1, 1'b0, 1'b0, 1'b0, exp_dl[1]);
    endtask

    function automatic logic [31:0] rand_addr(input int d);
        if ($urandom_range(0, 7) == 0) return $urandom;
        return base_of(d) + 32'($urandom_range(0, 63));
    endfunction

    initial begin
        logic eld, esd, eerr;
        int   op;
        tv[0]  = '{1'b0, 1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 1'b0, 1'b1, 1'b0, 32'h0};
        tv[1]  = '{1'b1, 1'b0, 32'h10,       32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF};
        tv[2]  = '{1'b0, 1'b1, 32'h20,       32'h11223344, 4'hF, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
        tv[3]  = '{1'b0, 1'b1, 32'h20,       32'h00AA0000, 4'h4, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
        tv[4]  = '{1'b1, 1'b0, 32'h20,       32'h0,        4'hF, 1'b1, 1'b0, 1'b0, 32'h11AA3344};
        tv[5]  = '{1'b0, 1'b1, 32'h20,       32'hFFFFFFFF, 4'h0, 1'b0, 1'b1, 1'b0, 32'h11AA3344};
        tv[6]  = '{1'b1, 1'b0, 32'h22,       32'h0,        4'h1, 1'b1, 1'b0, 1'b0, 32'h11AA3344};
        tv[7]  = '{1'b0, 1'b1, 32'h00,       32'hCAFEF00D, 4'hF, 1'b0, 1'b1, 1'b0, 32'h11AA3344};
        tv[8]  = '{1'b1, 1'b0, 32'h40,       32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'h0};
        tv[9]  = '{1'b0, 1'b1, 32'h40,       32'h12345678, 4'hF, 1'b0, 1'b1, 1'b1, 32'h0};
        tv[10] = '{1'b1, 1'b0, 32'h00,       32'h0,        4'hF, 1'b1, 1'b0, 1'b0, 32'hCAFEF00D};
        tv[11] = '{1'b1, 1'b0, 32'hFFFFFFFC, 32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'h0};
        tv[12] = '{1'b1, 1'b1, 32'h30,       32'h55667788, 4'hF, 1'b0, 1'b1, 1'b1, 32'h0};
        tv[13] = '{1'b1, 1'b0, 32'h30,       32'h0,        4'hF, 1'b1, 1'b0, 1'b0, 32'h55667788};
        tv[14] = '{1'b0, 1'b0, 32'h30,       32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 32'h55667788};

        exp_dl[0] = 32'h0;
        exp_dl[1] = 32'h0;
        for (int d = 0; d < 2; d++) drive(d, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) chk_outs(d, "reset", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b0;

        // Zero-wait instance: back-to-back directed vectors, one accept per cycle.
        for (int i = 0; i < 15; i++) begin
            model(0, tv[i].l, tv[i].s, tv[i].a, tv[i].w, tv[i].se, eld, esd, eerr);
            drive(0, tv[i].l, tv[i].s, tv[i].a, tv[i].w, tv[i].se);
            @(posedge clk);
            @(negedge clk);
            chk_outs(0, $sformatf("vec%0d", i), 1'b1, tv[i].eld, tv[i].esd, tv[i].eerr, tv[i].edl);
        end

        for (int i = 0; i < 16; i++) step0(1'b0, 1'b1, 32'(i * 4), $urandom, 4'hF);
        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 9);
            step0(op >= 2 && op <= 5 || op == 9, op >= 6, rand_addr(0), $urandom,
                  4'($urandom_range(0, 15)));
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // Three-wait instance: directed corner cases.
        access1(1'b0, 1'b1, 32'h100, 32'h11223344, 4'hF, "ws3_store");
        access1(1'b0, 1'b1, 32'h100, 32'h00AA0000, 4'h4, "ws3_lane");
        access1(1'b1, 1'b0, 32'h100, 32'h0,        4'h0, "ws3_load");
        access1(1'b1, 1'b0, 32'h140, 32'h0,        4'hF, "ws3_oow_load");
        access1(1'b0, 1'b1, 32'h140, 32'hFFFFFFFF, 4'hF, "ws3_oow_store");
        access1(1'b1, 1'b0, 32'h0FC, 32'h0,        4'hF, "ws3_below_base");
        access1(1'b1, 1'b0, 32'h100, 32'h0,        4'hF, "ws3_reload");
        access1(1'b1, 1'b1, 32'h104, 32'h99887766, 4'hF, "ws3_both");
        access1(1'b1, 1'b0, 32'h104, 32'h0,        4'hF, "ws3_both_rd");

        // Reset in the middle of a store's wait window aborts it.
        access1(1'b0, 1'b1, 32'h108, 32'h0BADF00D, 4'hF, "ws3_pre_rst");
        drive(1, 1'b0, 1'b1, 32'h108, 32'hFFFFFFFF, 4'hF);
        @(posedge clk);
        @(negedge clk);
        chk_outs(1, "rst_wait_busy", 1'b0, 1'b0, 1'b0, 1'b0, exp_dl[1]);
        rst = 1'b1;
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        chk_outs(1, "rst_async", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_dl[0] = 32'h0;
        exp_dl[1] = 32'h0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            chk_outs(1, "rst_no_done", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        end
        access1(1'b1, 1'b0, 32'h108, 32'h0, 4'hF, "rst_old_word");

        for (int i = 0; i < 16; i++)
            access1(1'b0, 1'b1, 32'h100 + 32'(i * 4), $urandom, 4'hF, "ws3_init");
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(2, 9);
            access1(op <= 5 || op == 9, op >= 6, rand_addr(1), $urandom,
                    4'($urandom_range(0, 15)), "rand_ws3");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
